asp_stage3_ctrl: RTL

ASP_STAGE3_CTRL -- requirements
Module: asp_stage3_ctrl

---
 rtl/asp_stage3_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/asp_stage3_ctrl.sv
// ---------------------------------------------------------------------------
// asp_stage3_ctrl
// Stage-3 dispatch controller. Accepts one decoded transaction from the
// stage-3 registers, routes it either to the network (clean TX) or back to
// the host (RX payloads and every error class), and keeps saturating
// statistics counters for completed network frames and error events.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module asp_stage3_ctrl #(
    parameter int data_size = 32,
    parameter int tag_size  = 8,
    parameter int cnt_size  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    opcode,
    input  logic                          soft_error,
    input  logic                          tag_match,
    input  logic [data_size-1:0]          rx_data,
    input  logic [data_size-1:0]          tx_data,
    input  logic [data_size+tag_size-1:0] tx_data_plus_tag,
    output logic                          net_valid,
    input  logic                          net_ready,
    output logic [data_size+tag_size-1:0] net_data,
    output logic                          host_valid,
    input  logic                          host_ready,
    output logic [data_size-1:0]          host_data,
    output logic [1:0]                    host_status,
    input  logic                          cnt_clear,
    output logic [cnt_size-1:0]           tx_count,
    output logic [cnt_size-1:0]           err_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_NET  = 2'd1,
        ST_SEND_HOST = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_TX  = 2'b01;
    localparam logic [1:0] OP_RX  = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    localparam logic [1:0] STS_RX_OK    = 2'b00;
    localparam logic [1:0] STS_SOFT_ERR = 2'b01;
    localparam logic [1:0] STS_TAG_ERR  = 2'b10;
    localparam logic [1:0] STS_BAD_OP   = 2'b11;

    // Saturating increment: an all-ones counter holds its value.
    function automatic logic [cnt_size-1:0] sat_inc(input logic [cnt_size-1:0] v);
        logic [cnt_size-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(cnt_size-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t                          state_r;
    state_t                          state_nx_s;
    logic                            in_ready_r;
    logic                            net_valid_r;
    logic                            host_valid_r;
    logic [data_size+tag_size-1:0]   net_data_r;
    logic [data_size-1:0]            host_data_r;
    logic [1:0]                      host_status_r;
    logic [cnt_size-1:0]             tx_count_r;
    logic [cnt_size-1:0]             err_count_r;

    logic                            load_net_s;
    logic                            load_host_s;
    logic [data_size-1:0]            host_data_nx_s;
    logic [1:0]                      host_status_nx_s;
    logic                            err_event_s;
    logic                            tx_done_s;

    // Next-state decode, holding-register load strobes and counter events.
    always_comb begin
        state_nx_s       = state_r;
        load_net_s       = 1'b0;
        load_host_s      = 1'b0;
        host_data_nx_s   = {data_size{1'b0}};
        host_status_nx_s = STS_RX_OK;
        err_event_s      = 1'b0;
        tx_done_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // in_ready is high only here, so in_valid alone means acceptance
                if (in_valid) begin
                    case (opcode)
                        OP_NOP: begin
                            state_nx_s = ST_IDLE;
                        end
                        OP_TX: begin
                            if (soft_error) begin
                                state_nx_s       = ST_SEND_HOST;
                                load_host_s      = 1'b1;
                                host_data_nx_s   = tx_data;
                                host_status_nx_s = STS_SOFT_ERR;
                                err_event_s      = 1'b1;
                            end else begin
                                state_nx_s = ST_SEND_NET;
                                load_net_s = 1'b1;
                            end
                        end
                        OP_RX: begin
                            state_nx_s     = ST_SEND_HOST;
                            load_host_s    = 1'b1;
                            host_data_nx_s = rx_data;
                            if (tag_match) begin
                                host_status_nx_s = STS_RX_OK;
                            end else begin
                                host_status_nx_s = STS_TAG_ERR;
                                err_event_s      = 1'b1;
                            end
                        end
                        OP_BAD: begin
                            state_nx_s       = ST_SEND_HOST;
                            load_host_s      = 1'b1;
                            host_data_nx_s   = {data_size{1'b0}};
                            host_status_nx_s = STS_BAD_OP;
                            err_event_s      = 1'b1;
                        end
                        default: begin
                            state_nx_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND_NET: begin
                if (net_ready) begin
                    state_nx_s = ST_IDLE;
                    tx_done_s  = 1'b1;
                end else begin
                    state_nx_s = ST_SEND_NET;
                end
            end
            ST_SEND_HOST: begin
                if (host_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SEND_HOST;
                end
            end
            default: begin
                // unreachable encoding: recover to a safe idle state
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register plus flopped handshake outputs derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            in_ready_r   <= 1'b1;
            net_valid_r  <= 1'b0;
            host_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            in_ready_r   <= (state_nx_s == ST_IDLE);
            net_valid_r  <= (state_nx_s == ST_SEND_NET);
            host_valid_r <= (state_nx_s == ST_SEND_HOST);
        end
    end

    // Holding registers: loaded only on acceptance, so they stay stable while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            net_data_r    <= {(data_size+tag_size){1'b0}};
            host_data_r   <= {data_size{1'b0}};
            host_status_r <= STS_RX_OK;
        end else begin
            if (load_net_s) begin
                net_data_r <= tx_data_plus_tag;
            end
            if (load_host_s) begin
                host_data_r   <= host_data_nx_s;
                host_status_r <= host_status_nx_s;
            end
        end
    end

    // Statistics counters: synchronous clear dominates, increments saturate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_count_r  <= {cnt_size{1'b0}};
            err_count_r <= {cnt_size{1'b0}};
        end else if (cnt_clear) begin
            tx_count_r  <= {cnt_size{1'b0}};
            err_count_r <= {cnt_size{1'b0}};
        end else begin
            if (tx_done_s) begin
                tx_count_r <= sat_inc(tx_count_r);
            end
            if (err_event_s) begin
                err_count_r <= sat_inc(err_count_r);
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign net_valid   = net_valid_r;
    assign host_valid  = host_valid_r;
    assign net_data    = net_data_r;
    assign host_data   = host_data_r;
    assign host_status = host_status_r;
    assign tx_count    = tx_count_r;
    assign err_count   = err_count_r;

endmodule
